// File: rtl/bp_pkg.sv
// bp_pkg: entry type, reset constants and PC slice helper for branch_predictor.
// Defining BP_TAG_EN adds a per-entry tag field.
package bp_pkg;

   localparam int CTR_W_MAX = 4;
   localparam int TAG_W_MAX = 30;

   typedef logic [CTR_W_MAX-1:0] bp_ctr_t;
`ifdef BP_TAG_EN
   typedef logic [TAG_W_MAX-1:0] bp_tag_t;
`endif

   // Fields are sized for the widest legal build; narrower builds leave
   // the upper bits at zero.
   typedef struct packed {
      logic        valid;
`ifdef BP_TAG_EN
      bp_tag_t     tag;
`endif
      logic [31:0] target;
      bp_ctr_t     ctr;
   } bp_entry_t;

   function automatic bp_ctr_t bp_wt(input int bits);
      return bp_ctr_t'(1) << (bits - 1);
   endfunction

   function automatic bp_ctr_t bp_wnt(input int bits);
      return bp_wt(bits) - bp_ctr_t'(1);
   endfunction

   function automatic logic [31:0] bp_slice(input logic [31:0] pc,
                                            input int lo,
                                            input int w);
      return (pc >> lo) & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr: next value of a CTR_BITS-wide saturating up/down counter.
module bp_sat_ctr
   import bp_pkg::*;
#(
   parameter int CTR_BITS = 2
)(
   input  bp_ctr_t i_ctr,
   input  logic    i_inc,
   output bp_ctr_t o_ctr
);

   localparam bp_ctr_t MAX = bp_ctr_t'((1 << CTR_BITS) - 1);

   always_comb begin
      o_ctr = i_ctr;
      if (i_inc) begin
         if (i_ctr != MAX) o_ctr = i_ctr + bp_ctr_t'(1);
      end else if (i_ctr != '0) begin
         o_ctr = i_ctr - bp_ctr_t'(1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating direction counters.
// Optional tag match per entry when BP_TAG_EN is defined.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES  = 16,
   parameter int CTR_BITS = 2,
   parameter int TAG_BITS = 8
)(
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] lookup_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        resolve_valid,
   input  logic [31:0] resolve_pc,
   input  logic        resolve_taken,
   input  logic [31:0] resolve_target,
   input  logic        resolve_pred_taken,
   input  logic [31:0] resolve_pred_target,
   output logic        mispredict,
   output logic [31:0] correct_pc,
   input  logic        clear
);

   localparam int      IDX_W = $clog2(ENTRIES);
   localparam bp_ctr_t WT    = bp_wt(CTR_BITS);
   localparam bp_ctr_t WNT   = bp_wnt(CTR_BITS);

   if (ENTRIES < 2 || ENTRIES > 1024 || (ENTRIES & (ENTRIES - 1)) != 0 ||
       CTR_BITS < 1 || CTR_BITS > CTR_W_MAX ||
       TAG_BITS < 1 || TAG_BITS > TAG_W_MAX - IDX_W) begin : g_bad_param
      $error("branch_predictor: illegal parameter set");
   end

   bp_entry_t        r_tab [ENTRIES];
   logic [IDX_W-1:0] w_lidx;
   logic [IDX_W-1:0] w_ridx;
   bp_entry_t        w_lent;
   bp_entry_t        w_rent;
   bp_entry_t        w_new;
   logic             w_lhit;
   logic             w_rhit;
   bp_ctr_t          w_nctr;

   assign w_lidx = IDX_W'(bp_slice(lookup_pc, 2, IDX_W));
   assign w_ridx = IDX_W'(bp_slice(resolve_pc, 2, IDX_W));
   assign w_lent = r_tab[w_lidx];
   assign w_rent = r_tab[w_ridx];

`ifdef BP_TAG_EN
   assign w_lhit = w_lent.valid &&
      (w_lent.tag == bp_tag_t'(bp_slice(lookup_pc, IDX_W + 2, TAG_BITS)));
   assign w_rhit = w_rent.valid &&
      (w_rent.tag == bp_tag_t'(bp_slice(resolve_pc, IDX_W + 2, TAG_BITS)));
`else
   assign w_lhit = w_lent.valid;
   assign w_rhit = w_rent.valid;
`endif

   assign pred_taken  = w_lhit & w_lent.ctr[CTR_BITS-1];
   assign pred_target = pred_taken ? w_lent.target : lookup_pc + 32'd4;

   assign mispredict = resolve_valid &
      ((resolve_pred_taken != resolve_taken) |
       (resolve_taken & (resolve_pred_target != resolve_target)));
   assign correct_pc = resolve_taken ? resolve_target : resolve_pc + 32'd4;

   bp_sat_ctr #(.CTR_BITS(CTR_BITS)) u_ctr (
      .i_ctr (w_rent.ctr),
      .i_inc (resolve_taken),
      .o_ctr (w_nctr)
   );

   always_comb begin
      w_new        = '0;
      w_new.valid  = 1'b1;
`ifdef BP_TAG_EN
      w_new.tag    = bp_tag_t'(bp_slice(resolve_pc, IDX_W + 2, TAG_BITS));
`endif
      w_new.target = resolve_target;
      w_new.ctr    = WT;
   end

   // clear outranks training so a flushed table never sees a fresh allocation
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_tab[i]     <= '0;
            r_tab[i].ctr <= WNT;
         end
      end else if (clear) begin
         for (int i = 0; i < ENTRIES; i++) r_tab[i].valid <= 1'b0;
      end else if (resolve_valid) begin
         if (w_rhit) begin
            r_tab[w_ridx].ctr <= w_nctr;
            if (resolve_taken) r_tab[w_ridx].target <= resolve_target;
         end else if (resolve_taken) begin
            r_tab[w_ridx] <= w_new;
         end
      end
   end

endmodule
